i2s_pcm_loader: RTL and testbench
=================================

# i2s_pcm_loader

Buffered PCM sample source that sits directly upstream of the MAX98357 I2S transmitter. Accepts a little-endian byte stream (UART/SD loader) and packs it into BIT_DEPTH-bit mono words. Stores the words in a FIFO and hands one word per stereo frame to the serializer on request. Replaces the synthesis-time preloaded audio memories with a runtime-streamed source; a prime/refill state machine prevents startup and underrun clicks.

## Interface
Parameters:
- BIT_DEPTH, 16: sample width; fixed at 16 (two bytes per word).
- FIFO_DEPTH, 1024: word capacity; must be a power of 2.
- ADDR_W, $clog2(FIFO_DEPTH): FIFO pointer width.
- PRIME_LEVEL, 512: fill level that starts or resumes playback; must satisfy 1 ≤ PRIME_LEVEL ≤ FIFO_DEPTH.

Ports:
- MCLK  in  1  100 MHz system clock; all logic is on posedge MCLK.
- rst_n  in  1  asynchronous, active-low reset.
- in_byte  in  8  stream byte, low byte of each sample first.
- in_valid  in  1  in_byte is valid.
- in_ready  out  1  a byte is accepted when in_valid && in_ready.
- word_req  in  1  single-MCLK pulse from the serializer, once per LRCLK frame, asserted at the word-load point.
- word_out  out  BIT_DEPTH  current sample; held between requests.
- word_valid  out  1  one-cycle pulse when word_out has been updated from the FIFO.
- flush  in  1  synchronous clear of FIFO, assembler and flags.
- playing  out  1  high in PLAY state.
- underrun  out  1  sticky flag; set on an empty FIFO in PLAY; cleared by flush.
- level  out  ADDR_W+1  number of words in the FIFO.

## Operation
- Byte assembler:
  - A phase bit selects the byte slot. Phase 0 stores in_byte into lo_reg.
  - Phase 1 pushes {in_byte, lo_reg} into the FIFO, then returns to phase 0.
  - in_ready = ~full. The low byte is also stalled when full, so no holding state is needed.
- FIFO:
  - Circular buffer with ADDR_W+1-bit read/write pointers. Wrap is by natural overflow.
  - full when pointers differ only in the MSB; empty when the pointers are equal.
  - level = wr_ptr − rd_ptr, taken modulo 2^(ADDR_W+1).
- State machine (states FILL, PLAY):
  - FILL: word_req loads word_out <= 0 (silence). No pop, no word_valid, no underrun. Go to PLAY when level ≥ PRIME_LEVEL.
  - PLAY, word_req && !empty: pop. word_out <= FIFO head. word_valid pulses.
  - PLAY, word_req && empty: word_out <= 0, underrun <= 1, go to FILL.
- Flush (priority over all other logic):
  - Pointers to 0, phase to 0, state to FILL, underrun to 0, word_out to 0.
  - A byte offered during flush is dropped.
- The serializer transmits word_out on both channels. This block is mono.

## Timing
- Reset values: in_ready = 1, word_out = 0, word_valid = 0, playing = 0, underrun = 0, level = 0, state FILL, phase 0.
- Push: the word is visible in level one cycle after the high-byte handshake.
- Pop: word_out and word_valid update on the cycle after word_req (1-cycle latency). The serializer must sample word_out at least 2 MCLK after word_req, which is trivial at its SCLK rate.
- Same cycle push + pop: both occur; level is unchanged.
- Full: in_ready is low. A pop in that cycle raises in_ready the next cycle. There is no same-cycle pass-through.
- Empty + push + word_req in PLAY: this is an underrun (no bypass); the pushed word stays in the FIFO.
- FILL → PLAY: the transition is registered. A word_req in the same cycle the threshold is reached is still served as silence.
- word_req while flush is high: ignored.
- Asynchronous reset mid-byte-pair: the partial lo_reg is discarded.

## Structure
- Shared package i2s_pkg:
  - BIT_DEPTH and SAMP_RATE constants.
  - State enum {FILL, PLAY}.
  - Silence word constant = 16'h0000.
- One sub-module, sync_fifo: parameterised on width and depth, with push/pop/full/empty/level, inferred as BRAM with a registered read.
- The top level holds the assembler, the state machine and the word_out register.
- Rule for sync_fifo's registered read: issue the read address combinationally on pop so that word_out still meets the 1-cycle latency.

## Test plan
- Reset, then 8 word_req pulses with no input → word_out = 0 throughout, word_valid never asserts, underrun = 0, playing = 0.
- Stream 2·PRIME_LEVEL bytes of the samples 0x0001..0x0200 (low byte first) → playing rises one cycle after level = 512. The next requests return 0x0001, 0x0002, … each with a word_valid pulse.
- Fill to 1024 words → in_ready = 0 and level = 1024. One word_req → in_ready = 1 next cycle, level = 1023. A wrap-around push and pop preserves order.
- In PLAY, drain to empty, then word_req → word_out = 0, underrun = 1, state FILL. Refilling to 512 resumes playback; underrun stays 1.
- Send a low byte 0xAA, then flush, then bytes 0x34, 0x12 → the first word stored is 0x1234 and level = 1. Afterwards underrun = 0 and playing = 0.
- Assert rst_n low mid-PLAY between word_req pulses → all outputs return to their reset values asynchronously. The serializer then receives silence until the FIFO is primed again.

Source files
------------

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared constants and state type for the I2S PCM path
package i2s_pkg;

  localparam int PCM_BIT_DEPTH = 16;
  localparam int PCM_SAMP_RATE = 48000;

  localparam logic [15:0] SILENCE = 16'h0000;

  typedef enum logic {
    FILL = 1'b0,
    PLAY = 1'b1
  } state_t;

endpackage

// File: rtl/i2s_pcm_loader_sync_fifo.sv
// rtl/i2s_pcm_loader_sync_fifo.sv - block-RAM FIFO with registered read port
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          MCLK,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [WIDTH-1:0] din,
  input  logic          pop,
  output logic [WIDTH-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra MSB on each pointer separates full from empty; wrap is natural overflow.
  assign full  = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign empty = (wr_ptr == rd_ptr);
  assign level = wr_ptr - rd_ptr;

  // Pointer update; clr wins over any push or pop in the same cycle.
  always_ff @(posedge MCLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // RAM write port and registered read; the read address is the current rd_ptr,
  // so the head word lands in dout on the edge that consumes it.
  always_ff @(posedge MCLK) begin
    if (push && !clr) mem[wr_ptr[AW-1:0]] <= din;
    if (pop && !clr)  dout <= mem[rd_ptr[AW-1:0]];
  end

endmodule

// File: rtl/i2s_pcm_loader.sv
// rtl/i2s_pcm_loader.sv - byte-stream to mono PCM word source with prime/refill control
module i2s_pcm_loader
  import i2s_pkg::*;
#(
  parameter int BIT_DEPTH   = PCM_BIT_DEPTH,
  parameter int FIFO_DEPTH  = 1024,
  parameter int ADDR_W      = $clog2(FIFO_DEPTH),
  parameter int PRIME_LEVEL = 512
) (
  input  logic                 MCLK,
  input  logic                 rst_n,
  input  logic [7:0]           in_byte,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 word_req,
  output logic [BIT_DEPTH-1:0] word_out,
  output logic                 word_valid,
  input  logic                 flush,
  output logic                 playing,
  output logic                 underrun,
  output logic [ADDR_W:0]      level
);

  localparam logic [ADDR_W:0] PRIME_LVL = (ADDR_W+1)'(PRIME_LEVEL);

  state_t               state_q;
  state_t               state_d;
  logic                 phase_q;
  logic [7:0]           lo_reg;
  logic                 push;
  logic                 pop;
  logic                 load_silence;
  logic                 set_underrun;
  logic                 silence_q;
  logic                 full;
  logic                 empty;
  logic [BIT_DEPTH-1:0] fifo_dout;

  // A pending low byte is also held off while full, so the pair never splits.
  assign in_ready = ~full;
  assign push     = in_valid && in_ready && phase_q && !flush;
  assign playing  = (state_q == PLAY);

  sync_fifo #(
    .WIDTH (BIT_DEPTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (ADDR_W)
  ) u_fifo (
    .MCLK  (MCLK),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (push),
    .din   ({in_byte, lo_reg}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Byte assembler: phase 0 captures the low byte, phase 1 completes the word.
  always_ff @(posedge MCLK or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      lo_reg  <= 8'h00;
    end else if (flush) begin
      phase_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      if (!phase_q) lo_reg <= in_byte;
      phase_q <= ~phase_q;
    end
  end

  // Next-state and per-request decisions; flush suppresses every request.
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    load_silence = 1'b0;
    set_underrun = 1'b0;
    if (!flush) begin
      case (state_q)
        FILL: begin
          if (word_req) load_silence = 1'b1;
          if (level >= PRIME_LVL) state_d = PLAY;
        end
        PLAY: begin
          if (word_req) begin
            if (!empty) begin
              pop = 1'b1;
            end else begin
              load_silence = 1'b1;
              set_underrun = 1'b1;
              state_d      = FILL;
            end
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // State register; flush forces a fresh prime.
  always_ff @(posedge MCLK or negedge rst_n) begin
    if (!rst_n)     state_q <= FILL;
    else if (flush) state_q <= FILL;
    else            state_q <= state_d;
  end

  // Output flags; silence_q masks the RAM read register so word_out reads zero.
  always_ff @(posedge MCLK or negedge rst_n) begin
    if (!rst_n) begin
      word_valid <= 1'b0;
      silence_q  <= 1'b1;
      underrun   <= 1'b0;
    end else if (flush) begin
      word_valid <= 1'b0;
      silence_q  <= 1'b1;
      underrun   <= 1'b0;
    end else begin
      word_valid <= pop;
      if (load_silence)      silence_q <= 1'b1;
      else if (pop)          silence_q <= 1'b0;
      if (set_underrun)      underrun  <= 1'b1;
    end
  end

  assign word_out = silence_q ? SILENCE : fifo_dout;

endmodule

// File: tb/tb_i2s_pcm_loader.sv
// tb/tb_i2s_pcm_loader.sv - directed self-checking bench for i2s_pcm_loader
module tb_i2s_pcm_loader;

  logic        MCLK = 1'b0;
  logic        rst_n;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic        word_req;
  logic [15:0] word_out;
  logic        word_valid;
  logic        flush;
  logic        playing;
  logic        underrun;
  logic [10:0] level;

  int tests  = 0;
  int failed = 0;

  i2s_pcm_loader dut (
    .MCLK       (MCLK),
    .rst_n      (rst_n),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .word_req   (word_req),
    .word_out   (word_out),
    .word_valid (word_valid),
    .flush      (flush),
    .playing    (playing),
    .underrun   (underrun),
    .level      (level)
  );

  always #5 MCLK = ~MCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w);
    in_valid = 1'b1;
    in_byte  = w[7:0];
    tick();
    in_byte  = w[15:8];
    tick();
    in_valid = 1'b0;
  endtask

  task automatic request();
    word_req = 1'b1;
    tick();
    word_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_byte = 8'h00; in_valid = 1'b0; word_req = 1'b0; flush = 1'b0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_word_out", word_out, 0);
    chk("rst_word_valid", word_valid, 0);
    chk("rst_playing", playing, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_level", level, 0);
    rst_n = 1'b1;
    tick();

    // Requests with an empty FIFO in FILL give silence only.
    for (int i = 0; i < 8; i++) begin
      request();
      chk("idle_word_out", word_out, 0);
      chk("idle_word_valid", word_valid, 0);
    end
    chk("idle_underrun", underrun, 0);
    chk("idle_playing", playing, 0);

    // Prime with 0x0001..0x0200.
    for (int i = 1; i <= 511; i++) send_word(16'(i));
    chk("prime_level_511", level, 511);
    chk("prime_not_playing", playing, 0);
    send_word(16'h0200);
    chk("prime_level_512", level, 512);
    chk("prime_still_fill", playing, 0);
    request();
    chk("threshold_req_silence_valid", word_valid, 0);
    chk("threshold_req_silence_word", word_out, 0);
    chk("threshold_playing", playing, 1);
    chk("threshold_level", level, 512);
    for (int i = 1; i <= 3; i++) begin
      request();
      chk("play_word_out", word_out, i);
      chk("play_word_valid", word_valid, 1);
    end
    tick();
    chk("play_valid_pulse_low", word_valid, 0);
    chk("play_level_509", level, 509);

    // Fill to capacity; further bytes must be refused.
    for (int i = 16'h0201; i <= 16'h0403; i++) send_word(16'(i));
    chk("full_level", level, 1024);
    chk("full_in_ready", in_ready, 0);
    in_valid = 1'b1; in_byte = 8'hEE;
    tick();
    in_valid = 1'b0;
    chk("full_byte_refused", level, 1024);
    request();
    chk("full_pop_word", word_out, 16'h0004);
    chk("full_pop_in_ready", in_ready, 1);
    chk("full_pop_level", level, 1023);

    // Same-cycle push and pop.
    in_valid = 1'b1; in_byte = 8'h04;
    tick();
    in_byte = 8'h04; word_req = 1'b1;
    tick();
    in_valid = 1'b0; word_req = 1'b0;
    chk("pushpop_word", word_out, 16'h0005);
    chk("pushpop_valid", word_valid, 1);
    chk("pushpop_level", level, 1023);

    // Drain across the wrap, checking order.
    for (int i = 16'h0006; i <= 16'h0404; i++) begin
      request();
      chk("drain_word", word_out, i);
    end
    chk("drain_level", level, 0);
    request();
    chk("underrun_word", word_out, 0);
    chk("underrun_valid", word_valid, 0);
    chk("underrun_flag", underrun, 1);
    chk("underrun_to_fill", playing, 0);

    // Refill resumes playback, underrun stays sticky.
    for (int i = 0; i < 512; i++) send_word(16'h1000 + 16'(i));
    chk("refill_fill", playing, 0);
    tick();
    chk("refill_playing", playing, 1);
    chk("refill_underrun_sticky", underrun, 1);
    request();
    chk("refill_first_word", word_out, 16'h1000);

    // Flush discards the pending low byte and all state.
    in_valid = 1'b1; in_byte = 8'hAA;
    tick();
    in_valid = 1'b0; flush = 1'b1; word_req = 1'b1;
    tick();
    flush = 1'b0; word_req = 1'b0;
    chk("flush_level", level, 0);
    chk("flush_underrun", underrun, 0);
    chk("flush_playing", playing, 0);
    chk("flush_word_out", word_out, 0);
    chk("flush_req_ignored", word_valid, 0);
    send_word(16'h1234);
    chk("flush_after_level", level, 1);
    for (int i = 0; i < 511; i++) send_word(16'h2000 + 16'(i));
    tick();
    chk("flush_reprime_playing", playing, 1);
    request();
    chk("flush_first_word", word_out, 16'h1234);

    // Asynchronous reset between requests in PLAY.
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_word_out", word_out, 0);
    chk("arst_word_valid", word_valid, 0);
    chk("arst_playing", playing, 0);
    chk("arst_underrun", underrun, 0);
    chk("arst_level", level, 0);
    chk("arst_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    request();
    chk("arst_req_silence", word_out, 0);
    chk("arst_req_valid", word_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
